spi_slave: RTL

- SPI peripheral (target) end of the link driven by the team's SPI master.
- Oversamples the SPI_CLK, SPI_EN and SPI_MOSI pins in the system clock domain.
- Shifts out TX words on SPI_MISO and delivers each received word as a one-cycle rx_valid strobe.
- A one-entry TX holding buffer with a valid/ready handshake lets the host queue the next word while the current word shifts; SPI_EN held high gives back-to-back words.

---
 rtl/spi_slave_if.sv | 31 +++
 rtl/spi_slave.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// Host-side bus of the SPI target: TX holding-buffer handshake plus RX word strobe.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;

    // Host side: queues TX words, consumes RX words.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid,
        input  busy
    );

    // SPI target side.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid,
        output busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI target (peripheral). SPI_CLK, SPI_EN and SPI_MOSI are oversampled in the
// clk domain, so clk must run at least 4x the SPI_CLK frequency. A one-entry TX
// holding buffer lets the host queue the next word while the current one shifts.
// Optional status outputs (tx_underrun, frame_err) exist only when the macro
// SPI_SLAVE_STATUS_EN is defined.
module spi_slave #(
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    CPOL       = 1'b1,
    parameter bit                    CPHA       = 1'b0,
    parameter logic [DATA_WIDTH-1:0] TX_DEFAULT = '0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SPI_CLK,
    input  logic        SPI_EN,
    input  logic        SPI_MOSI,
    output logic        SPI_MISO,
`ifdef SPI_SLAVE_STATUS_EN
    output logic        tx_underrun,
    output logic        frame_err,
`endif
    spi_slave_if.slave  bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state_q, state_d;

    // Synchronizers: [0] first stage, [1] synced value, [2] (clock only) previous synced value.
    logic [2:0] sclk_sync;
    logic [1:0] en_sync;
    logic [1:0] mosi_sync;
    logic       en_prev;

    logic                  sclk_s;
    logic                  sclk_d;
    logic                  en_s;
    logic                  mosi_s;
    logic                  en_rise;
    logic                  lead_edge;
    logic                  trail_edge;
    logic                  sample_edge;
    logic                  shift_edge;

    // Datapath state.
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  miso_q;

    // TX holding buffer.
    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  buf_full;
    logic                  wr_accept;
    logic [DATA_WIDTH-1:0] load_word;

    // FSM decisions for this cycle.
    logic                  word_start;
    logic                  word_done;
    logic                  abort;
    logic                  do_sample;
    logic                  do_shift;

    assign sclk_s  = sclk_sync[1];
    assign sclk_d  = sclk_sync[2];
    assign en_s    = en_sync[1];
    assign mosi_s  = mosi_sync[1];
    assign en_rise = en_s && !en_prev;

    // Leading edge leaves the idle level CPOL; trailing edge returns to it.
    assign lead_edge   = (sclk_d == CPOL) && (sclk_s != CPOL);
    assign trail_edge  = (sclk_d != CPOL) && (sclk_s == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    assign wr_accept = bus.tx_valid && !buf_full;
    assign load_word = buf_full ? tx_buf : TX_DEFAULT;

    // Double-flop every pin; a third clock stage gives edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
        if (!rst) begin
            sclk_sync <= {3{CPOL}};
            en_sync   <= '0;
            mosi_sync <= '0;
            en_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], SPI_CLK};
            en_sync   <= {en_sync[0], SPI_EN};
            mosi_sync <= {mosi_sync[0], SPI_MOSI};
            en_prev   <= en_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and per-cycle datapath commands.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
        state_d    = state_q;
        word_start = 1'b0;
        word_done  = 1'b0;
        abort      = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_rise) begin
                    state_d    = ACTIVE;
                    word_start = 1'b1;
                end
            end
            ACTIVE: begin
                do_sample = sample_edge;
                word_done = sample_edge && (bit_cnt == LAST_BIT);
                // With CPHA=0 the trailing edge that follows the final sample lands on the
                // freshly loaded word (bit_cnt back at 0) and must not disturb it.
                do_shift  = shift_edge && en_s && (CPHA || (bit_cnt != '0));
                if (!en_s) begin
                    state_d = IDLE;
                    abort   = (bit_cnt != '0) && !word_done;
                end else if (word_done) begin
                    word_start = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift registers, bit counter, MISO and received-word register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_shift   <= '0;
            tx_shift   <= '0;
            bit_cnt    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            rx_valid_q <= word_done;
            if (word_done) begin
                rx_data_q <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            end

            if (do_sample) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end

            if (word_start) begin
                tx_shift <= load_word;
                bit_cnt  <= '0;
                // CPHA=0 presents the MSB before the first sample; CPHA=1 waits for the leading edge.
                if (!CPHA) begin
                    miso_q <= load_word[DATA_WIDTH-1];
                end
            end else if (do_shift) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                // CPHA=1 emits the current MSB then shifts; CPHA=0 already shows the MSB, so emit the next bit.
                miso_q   <= CPHA ? tx_shift[DATA_WIDTH-1] : tx_shift[DATA_WIDTH-2];
            end

            if ((state_q == ACTIVE) && (state_d == IDLE)) begin
                miso_q  <= 1'b0;
                bit_cnt <= '0;
            end
        end
    end

    // TX buffer occupancy: filled by an accepted write, emptied by a word start that uses it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_full <= 1'b0;
        end else if (wr_accept) begin
            buf_full <= 1'b1;
        end else if (word_start && buf_full) begin
            buf_full <= 1'b0;
        end
    end

    // TX buffer payload, qualified by buf_full.
    always_ff @(posedge clk) begin
        // NOTE: storage qualified by a valid flag needs no reset; only the flag is reset.
        if (wr_accept) begin
            tx_buf <= bus.tx_data;
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic tx_underrun_q;
    logic frame_err_q;

    // Status pulses: word started without a queued word, or select dropped mid-word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            tx_underrun_q <= word_start && !buf_full;
            frame_err_q   <= abort;
        end
    end

    assign tx_underrun = tx_underrun_q;
    assign frame_err   = frame_err_q;
`endif

    assign SPI_MISO     = miso_q;
    assign bus.tx_ready = !buf_full;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = (state_q == ACTIVE);

endmodule
